keypad_scanner: RTL
===================

// Module: keypad_scanner
// PURPOSE
// - Scans a 4x4 matrix keypad: drives one row low at a time and reads the active-low columns.
// - Debounces presses and releases.
// - Emits one key_valid pulse per debounced press, with a 4-bit hex key code.
// - Input-side counterpart of the multiplexed dual seven-segment driver; key_code feeds the display digit registers.
// - Runs on the HSOSC-derived system clock.
// PARAMETERS
// - SCAN_DIV         2400    clock cycles each row is driven before advancing (>=4)
// - DEBOUNCE_CYCLES  480000  consecutive stable cycles required to accept a press or release (>=2)
// PORTS
// - clk        input   1  system clock
// - reset      input   1  reset, asynchronous, active-high
// - col_n      input   4  keypad columns, active-low, externally pulled up, asynchronous to clk
// - row_n      output  4  keypad row drive, active-low, one-hot-low
// - key_valid  output  1  one-cycle pulse: new debounced key accepted
// - key_code   output  4  hex code of last accepted key; holds until next accept
// - key_held   output  1  high while the accepted key remains pressed (HELD state)
// BEHAVIOUR
// Reset values:
// - row_n=4'b1110, key_valid=0, key_code=4'h0, key_held=0, state=SCAN, all counters=0.
// - Reset asserted mid-operation aborts any debounce immediately; no key_valid is emitted.
// Input synchronisation:
// - col_n passes through a 2-flop synchronizer (col_s); all logic uses col_s only.
// - Synchronizer flops reset to 4'b1111.
// Row index and key map:
// - row index r: row_n = ~(4'b0001 << r).
// - Map row0: 1 2 3 A | row1: 4 5 6 B | row2: 7 8 9 C | row3: E 0 F D
//   (col0..col3 left to right; *=E, #=F).
// Column priority:
// - If several columns are low, the lowest column index wins.
// - The captured pattern is the full 4-bit col_s.
// FSM states:
// - SCAN:
//   - div_cnt counts 0..SCAN_DIV-1.
//   - At div_cnt==SCAN_DIV-1 with col_s==4'b1111: r <= r+1 (wrap 3->0), div_cnt <= 0.
//   - At div_cnt==SCAN_DIV-1 with col_s!=4'b1111: capture r and col_s, db_cnt <= 0, go DEBOUNCE.
//     The row does not advance.
//   - A column going low at any other div_cnt is ignored until the sample point.
// - DEBOUNCE:
//   - row_n frozen.
//   - Each cycle col_s==captured: db_cnt++.
//   - If col_s!=captured: go SCAN; div_cnt <= 0; r <= r+1; no output change.
//   - When db_cnt==DEBOUNCE_CYCLES-1 and still equal: go HELD.
//     On that same edge, key_code <= map(r, lowest low col), key_valid <= 1 for exactly one cycle, key_held <= 1.
// - HELD:
//   - row_n frozen, key_held=1.
//   - Other columns changing while the captured column stays low: ignored, no new key_valid.
//   - When the captured column reads high: db_cnt <= 0, go RELEASE.
// - RELEASE:
//   - key_held=0.
//   - Each cycle col_s==4'b1111: db_cnt++.
//   - Any low column: db_cnt <= 0 and stay in RELEASE. No re-trigger; bounce on release never produces a second pulse.
//   - When db_cnt==DEBOUNCE_CYCLES-1: go SCAN, div_cnt <= 0, r <= r+1.
// Latency and timing:
// - Press-to-key_valid = sync (2) + wait-to-sample (<=SCAN_DIV) + DEBOUNCE_CYCLES cycles.
// - Holding a key forever yields exactly one key_valid (no autorepeat).
// - Counters sized $clog2 of their parameter; no overflow, since they are cleared on every state entry.
// TESTING
// (bench params SCAN_DIV=4, DEBOUNCE_CYCLES=8; keypad model shorts row r to col c)
// 1. Reset, no key -> row_n cycles 1110,1101,1011,0111,1110 every 4 clks; key_valid never 1.
// 2. Hold key row1/col2 steady -> exactly one key_valid pulse, key_code=4'h6, key_held=1 until release;
//    after release, scanning resumes 8+ clks later.
// 3. Press row3/col1 with 3-clk bounce (low/high toggles) before stable -> bounce returns to SCAN;
//    after stable, single key_valid with key_code=4'h0.
// 4. Press row0/col0 and row0/col3 together -> key_code=4'h1 (lowest column), single key_valid.
// 5. Release with 5-clk bounce -> no second key_valid; key_held drops on first high sample;
//    SCAN re-entered only after 8 clean clks.
// 6. Assert reset midway through DEBOUNCE -> outputs return to reset values immediately, no key_valid;
//    after deassert, scanning restarts at row_n=1110.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low row strobe, debounces presses and releases,
// and reports one key_valid pulse with a hex key code per accepted press.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV        = 2400,
    parameter int unsigned DEBOUNCE_CYCLES = 480000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);

    localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DbW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
    localparam logic [DbW-1:0]  DbLast  = DbW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {StScan, StDebounce, StHeld, StRelease} state_e;

    state_e          state_q, state_d;
    logic [3:0]      col_meta_q, col_s_q;
    logic [1:0]      row_q, row_d;
    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic [DbW-1:0]  db_cnt_q, db_cnt_d;
    logic [3:0]      cap_col_q, cap_col_d;
    logic            key_valid_q, key_valid_d;
    logic [3:0]      key_code_q, key_code_d;
    logic            key_held_q, key_held_d;
    logic [1:0]      low_idx;

    // Row 3 carries the '*' and '#' keys, encoded as E and F.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Lowest low column of the captured pattern selects the key.
    always_comb begin
        if (!cap_col_q[0]) begin
            low_idx = 2'd0;
        end else if (!cap_col_q[1]) begin
            low_idx = 2'd1;
        end else if (!cap_col_q[2]) begin
            low_idx = 2'd2;
        end else begin
            low_idx = 2'd3;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        div_cnt_d   = div_cnt_q;
        db_cnt_d    = db_cnt_q;
        cap_col_d   = cap_col_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;

        case (state_q)
            StScan: begin
                if (div_cnt_q == DivLast) begin
                    div_cnt_d = '0;
                    if (col_s_q == 4'hF) begin
                        row_d = row_q + 2'd1;
                    end else begin
                        cap_col_d = col_s_q;
                        db_cnt_d  = '0;
                        state_d   = StDebounce;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DivW'(1);
                end
            end
            StDebounce: begin
                if (col_s_q != cap_col_q) begin
                    state_d   = StScan;
                    div_cnt_d = '0;
                    row_d     = row_q + 2'd1;
                end else if (db_cnt_q == DbLast) begin
                    state_d     = StHeld;
                    key_code_d  = key_map(row_q, low_idx);
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DbW'(1);
                end
            end
            StHeld: begin
                if (col_s_q[low_idx]) begin
                    db_cnt_d   = '0;
                    key_held_d = 1'b0;
                    state_d    = StRelease;
                end
            end
            StRelease: begin
                // Any bounce restarts the quiet period; no path back to a new press from here.
                if (col_s_q != 4'hF) begin
                    db_cnt_d = '0;
                end else if (db_cnt_q == DbLast) begin
                    state_d   = StScan;
                    div_cnt_d = '0;
                    row_d     = row_q + 2'd1;
                end else begin
                    db_cnt_d = db_cnt_q + DbW'(1);
                end
            end
            default: begin
                state_d = StScan;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_meta_q  <= 4'hF;
            col_s_q     <= 4'hF;
            state_q     <= StScan;
            row_q       <= 2'd0;
            div_cnt_q   <= '0;
            db_cnt_q    <= '0;
            cap_col_q   <= 4'hF;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            key_held_q  <= 1'b0;
        end else begin
            col_meta_q  <= col_n;
            col_s_q     <= col_meta_q;
            state_q     <= state_d;
            row_q       <= row_d;
            div_cnt_q   <= div_cnt_d;
            db_cnt_q    <= db_cnt_d;
            cap_col_q   <= cap_col_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
        end
    end

    assign row_n     = ~(4'b0001 << row_q);
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_held  = key_held_q;

endmodule
